// File: rtl/datamem_pkg.sv
// Shared types and constants for the data memory controller.
//   state_e    : controller FSM states (sweep / normal traffic)
//   RD_LAT     : cycles from request acceptance to rsp_valid
//   idx_width  : array index width for a given depth
// Build option: DATAMEM_OUT_REG_EN adds one output register stage (RD_LAT = 2).
package datamem_pkg;

  typedef enum logic [0:0] {
    StInit,
    StRun
  } state_e;

`ifdef DATAMEM_OUT_REG_EN
  localparam int unsigned RD_LAT = 2;
`else
  localparam int unsigned RD_LAT = 1;
`endif

  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/datamem_if.sv
// Request/response bus between a load/store requester and datamem_ctrl.
//   req_valid/req_ready/req_we/req_addr/req_wdata : request handshake
//   rsp_valid/rsp_data                            : read response
//   addr_err                                      : out-of-range pulse
//   init_done                                     : init sweep finished
// Modports: master (requester side), slave (memory controller side).
interface datamem_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 8
) ();

  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          addr_err;
  logic          init_done;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data, addr_err, init_done
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data, addr_err, init_done
  );

endinterface

// File: rtl/datamem_array.sv
// Plain synchronous single-port RAM, DEPTH x DW, registered read, no reset.
//   clk_i   : clock
//   we_i    : write enable
//   addr_i  : word index (must be < DEPTH)
//   wdata_i : write data
//   rdata_o : read data, valid the cycle after addr_i is presented (read-first)
module datamem_array #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned IW    = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [IW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/datamem_ctrl.sv
// Data memory controller: init sweep FSM, range check and read response pipeline
// around a DEPTH x DW synchronous array.
//   clk_i   : clock, rising edge
//   reset_i : asynchronous active-high reset
//   bus     : datamem_if.slave (request handshake, response, addr_err, init_done)
// After reset the array is swept (addr 0 <- PRELOAD0, addr 1 <- PRELOAD1, rest <- 0),
// then one request per cycle is accepted with no backpressure.
// Build option: DATAMEM_OUT_REG_EN registers rsp_valid/rsp_data/addr_err once more.
module datamem_ctrl
  import datamem_pkg::*;
#(
  parameter int unsigned   DW       = 8,
  parameter int unsigned   AW       = 8,
  parameter int unsigned   DEPTH    = 256,
  parameter logic [DW-1:0] PRELOAD0 = DW'(8'h04),
  parameter logic [DW-1:0] PRELOAD1 = DW'(8'h3C)
) (
  input  logic      clk_i,
  input  logic      reset_i,
  datamem_if.slave  bus
);

  localparam int unsigned IW = idx_width(DEPTH);

  state_e        state_q;
  logic [IW-1:0] ptr_q;
  logic          req_ready_q;
  logic          init_done_q;

  logic          accept;
  logic          in_range;
  logic          arr_we;
  logic [IW-1:0] arr_addr;
  logic [DW-1:0] arr_wdata;
  logic [DW-1:0] arr_rdata;

  // DEPTH <= 2**AW, so AW+1 bits hold it without truncation.
  assign in_range = ({1'b0, bus.req_addr} < (AW + 1)'(DEPTH));
  assign accept   = bus.req_valid & req_ready_q;

  // Array port mux: the sweep owns the array during init, the bus afterwards.
  always_comb begin
    arr_we    = 1'b0;
    arr_addr  = ptr_q;
    arr_wdata = '0;
    if (state_q == StInit) begin
      arr_we = 1'b1;
      if (ptr_q == IW'(0)) begin
        arr_wdata = PRELOAD0;
      end else if (ptr_q == IW'(1)) begin
        arr_wdata = PRELOAD1;
      end
    end else begin
      // Out-of-range addresses are steered to 0 so the array is never indexed past DEPTH.
      arr_addr  = in_range ? bus.req_addr[IW-1:0] : '0;
      arr_we    = accept & bus.req_we & in_range;
      arr_wdata = bus.req_wdata;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StInit;
      ptr_q       <= '0;
      req_ready_q <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        StInit: begin
          if (ptr_q == IW'(DEPTH - 1)) begin
            state_q     <= StRun;
            req_ready_q <= 1'b1;
            init_done_q <= 1'b1;
          end else begin
            ptr_q <= ptr_q + IW'(1);
          end
        end
        StRun: begin
        end
        default: begin
          state_q <= StInit;
        end
      endcase
    end
  end

  datamem_array #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (arr_we),
    .addr_i  (arr_addr),
    .wdata_i (arr_wdata),
    .rdata_o (arr_rdata)
  );

  // First response stage, aligned with the array's registered read data.
  logic          rd1_q;
  logic          err1_q;
  logic          oor1_q;
  logic [DW-1:0] hold_q;
  logic [DW-1:0] rsp1_data;

  // rsp_data keeps its last value between pulses; out-of-range reads return 0.
  assign rsp1_data = rd1_q ? (oor1_q ? '0 : arr_rdata) : hold_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd1_q  <= 1'b0;
      err1_q <= 1'b0;
      oor1_q <= 1'b0;
      hold_q <= '0;
    end else begin
      rd1_q  <= accept & ~bus.req_we;
      err1_q <= accept & ~in_range;
      oor1_q <= ~in_range;
      hold_q <= rsp1_data;
    end
  end

`ifdef DATAMEM_OUT_REG_EN
  logic          rd2_q;
  logic          err2_q;
  logic [DW-1:0] data2_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd2_q   <= 1'b0;
      err2_q  <= 1'b0;
      data2_q <= '0;
    end else begin
      rd2_q   <= rd1_q;
      err2_q  <= err1_q;
      data2_q <= rsp1_data;
    end
  end

  assign bus.rsp_valid = rd2_q;
  assign bus.addr_err  = err2_q;
  assign bus.rsp_data  = data2_q;
`else
  assign bus.rsp_valid = rd1_q;
  assign bus.addr_err  = err1_q;
  assign bus.rsp_data  = rsp1_data;
`endif

  assign bus.req_ready = req_ready_q;
  assign bus.init_done = init_done_q;

endmodule

// File: tb/tb_datamem_ctrl.sv
// Bench for datamem_ctrl: a DEPTH=256 instance checked every cycle against a
// behavioural model, plus a DEPTH=200 instance for out-of-range behaviour, with
// directed vectors and hand-computed expectations.
module tb_datamem_ctrl;
  import datamem_pkg::*;

  localparam int unsigned DEPTH   = 256;
  localparam int unsigned DEPTH_S = 200;
  localparam int unsigned L       = RD_LAT;

  logic clk_i = 1'b0;
  logic rst   = 1'b0;
  always #5 clk_i = ~clk_i;

  datamem_if #(.DW(8), .AW(8)) bus_m ();
  datamem_if #(.DW(8), .AW(8)) bus_s ();

  datamem_ctrl #(.DW(8), .AW(8), .DEPTH(DEPTH)) dut (
    .clk_i   (clk_i),
    .reset_i (rst),
    .bus     (bus_m)
  );

  datamem_ctrl #(.DW(8), .AW(8), .DEPTH(DEPTH_S)) dut_s (
    .clk_i   (clk_i),
    .reset_i (rst),
    .bus     (bus_s)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of the DEPTH=256 instance ----------------
  logic [7:0] mem_m [DEPTH];
  int         init_cnt;
  logic       pv [L];
  logic       pe [L];
  logic [7:0] pd [L];
  logic [7:0] hold_m;
  logic       ready_m;

  assign ready_m = (init_cnt == DEPTH) && !rst;

  always @(posedge clk_i or posedge rst) begin
    if (rst) begin
      init_cnt <= 0;
      hold_m   <= 8'h00;
      for (int k = 0; k < L; k++) begin
        pv[k] <= 1'b0;
        pe[k] <= 1'b0;
        pd[k] <= 8'h00;
      end
      for (int a = 0; a < DEPTH; a++) begin
        mem_m[a] <= (a == 0) ? 8'h04 : (a == 1) ? 8'h3C : 8'h00;
      end
    end else begin
      if (init_cnt < DEPTH) init_cnt <= init_cnt + 1;
      if (pv[L-1]) hold_m <= pd[L-1];
      for (int k = 1; k < L; k++) begin
        pv[k] <= pv[k-1];
        pe[k] <= pe[k-1];
        pd[k] <= pd[k-1];
      end
      pv[0] <= (init_cnt == DEPTH) && bus_m.req_valid && !bus_m.req_we;
      pe[0] <= (init_cnt == DEPTH) && bus_m.req_valid && (int'(bus_m.req_addr) >= DEPTH);
      pd[0] <= (int'(bus_m.req_addr) < DEPTH) ? mem_m[bus_m.req_addr] : 8'h00;
      if ((init_cnt == DEPTH) && bus_m.req_valid && bus_m.req_we &&
          (int'(bus_m.req_addr) < DEPTH)) begin
        mem_m[bus_m.req_addr] <= bus_m.req_wdata;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk_i) begin
    if ($time > 2) begin
      check("req_ready", {31'b0, bus_m.req_ready}, {31'b0, ready_m});
      check("init_done", {31'b0, bus_m.init_done}, {31'b0, ready_m});
      check("rsp_valid", {31'b0, bus_m.rsp_valid}, {31'b0, pv[L-1]});
      check("addr_err", {31'b0, bus_m.addr_err}, {31'b0, pe[L-1]});
      check("rsp_data", {24'b0, bus_m.rsp_data}, {24'b0, (pv[L-1] ? pd[L-1] : hold_m)});
    end
  end

  // ---------------- response event logs ----------------
  typedef struct {
    int         cyc;
    logic       v;
    logic       e;
    logic [7:0] d;
  } ev_t;

  ev_t log_m[$];
  ev_t log_s[$];
  ev_t ev_m;
  ev_t ev_s;

  always @(negedge clk_i) begin
    if (bus_m.rsp_valid || bus_m.addr_err) begin
      ev_m.cyc = cyc; ev_m.v = bus_m.rsp_valid; ev_m.e = bus_m.addr_err; ev_m.d = bus_m.rsp_data;
      log_m.push_back(ev_m);
    end
    if (bus_s.rsp_valid || bus_s.addr_err) begin
      ev_s.cyc = cyc; ev_s.v = bus_s.rsp_valid; ev_s.e = bus_s.addr_err; ev_s.d = bus_s.rsp_data;
      log_s.push_back(ev_s);
    end
  end

  task automatic expect_ev(input string name, input ev_t q[$], input int idx, input int exp_cyc,
                           input logic exp_v, input logic exp_e, input logic [7:0] exp_d);
    if (idx >= q.size()) begin
      checks++;
      failures++;
      $display("FAIL %s: response missing, got %0d events expected at least %0d",
               name, q.size(), idx + 1);
    end else begin
      check({name, "_cyc"}, q[idx].cyc, exp_cyc);
      check({name, "_flags"}, {30'b0, q[idx].v, q[idx].e}, {30'b0, exp_v, exp_e});
      check({name, "_data"}, {24'b0, q[idx].d}, {24'b0, exp_d});
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive_m(input logic v, input logic we, input logic [7:0] a, input logic [7:0] d,
                         output int dc);
    @(posedge clk_i);
    #1;
    bus_m.req_valid = v; bus_m.req_we = we; bus_m.req_addr = a; bus_m.req_wdata = d;
    dc = cyc;
  endtask

  task automatic drive_s(input logic v, input logic we, input logic [7:0] a, input logic [7:0] d,
                         output int dc);
    @(posedge clk_i);
    #1;
    bus_s.req_valid = v; bus_s.req_we = we; bus_s.req_addr = a; bus_s.req_wdata = d;
    dc = cyc;
  endtask

  task automatic drain();
    repeat (L + 3) @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (n < 1000) begin
      @(negedge clk_i);
      if (bus_m.req_ready) break;
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int c0, c1, c2, c3, cx;

    bus_m.req_valid = 1'b1; bus_m.req_we = 1'b0; bus_m.req_addr = 8'h00; bus_m.req_wdata = 8'h00;
    bus_s.req_valid = 1'b0; bus_s.req_we = 1'b0; bus_s.req_addr = 8'h00; bus_s.req_wdata = 8'h00;
    #1 rst = 1'b1;
    @(negedge clk_i);
    check("reset_rsp_valid", {31'b0, bus_m.rsp_valid}, 32'd0);
    check("reset_rsp_data", {24'b0, bus_m.rsp_data}, 32'd0);
    check("reset_ready", {31'b0, bus_m.req_ready}, 32'd0);
    repeat (2) @(posedge clk_i);
    #1 rst = 1'b0;

    // 1: req_ready low for exactly DEPTH cycles while req_valid is held.
    wait_ready(n);
    check("init_cycles", n, 256);
    check("init_done_up", {31'b0, bus_m.init_done}, 32'd1);
    check("init_done_s", {31'b0, bus_s.init_done}, 32'd1);
    drive_m(1'b0, 1'b0, 8'h00, 8'h00, cx);
    drain();
    log_m.delete();
    log_s.delete();

    // 2: preload values.
    drive_m(1'b1, 1'b0, 8'h00, 8'h00, c0);
    drive_m(1'b1, 1'b0, 8'h01, 8'h00, c1);
    drive_m(1'b1, 1'b0, 8'h02, 8'h00, c2);
    drive_m(1'b0, 1'b0, 8'h00, 8'h00, cx);
    drain();
    check("preload_count", log_m.size(), 3);
    expect_ev("preload0", log_m, 0, c0 + L, 1'b1, 1'b0, 8'h04);
    expect_ev("preload1", log_m, 1, c1 + L, 1'b1, 1'b0, 8'h3C);
    expect_ev("preload2", log_m, 2, c2 + L, 1'b1, 1'b0, 8'h00);
    log_m.delete();

    // 3: write then read-back, including the last address.
    drive_m(1'b1, 1'b1, 8'h10, 8'hA5, cx);
    drive_m(1'b1, 1'b0, 8'h10, 8'h00, c0);
    drive_m(1'b1, 1'b1, 8'hFF, 8'h5A, cx);
    drive_m(1'b1, 1'b0, 8'hFF, 8'h00, c1);
    drive_m(1'b0, 1'b0, 8'h00, 8'h00, cx);
    drain();
    check("wr_rd_count", log_m.size(), 2);
    expect_ev("rd_after_wr", log_m, 0, c0 + L, 1'b1, 1'b0, 8'hA5);
    expect_ev("rd_last_addr", log_m, 1, c1 + L, 1'b1, 1'b0, 8'h5A);
    log_m.delete();

    // 4: DEPTH=200 instance, out-of-range write dropped and read returns 0.
    drive_s(1'b1, 1'b1, 8'hC8, 8'h77, c0);
    drive_s(1'b1, 1'b0, 8'hC8, 8'h00, c1);
    drive_s(1'b1, 1'b0, 8'h00, 8'h00, c2);
    drive_s(1'b1, 1'b0, 8'hC7, 8'h00, c3);
    drive_s(1'b0, 1'b0, 8'h00, 8'h00, cx);
    drain();
    check("oor_count", log_s.size(), 4);
    expect_ev("oor_wr", log_s, 0, c0 + L, 1'b0, 1'b1, 8'h00);
    expect_ev("oor_rd", log_s, 1, c1 + L, 1'b1, 1'b1, 8'h00);
    expect_ev("oor_no_alias", log_s, 2, c2 + L, 1'b1, 1'b0, 8'h04);
    expect_ev("oor_last_addr", log_s, 3, c3 + L, 1'b1, 1'b0, 8'h00);

    // 5: reset right after a read is accepted discards it and re-sweeps.
    log_m.delete();
    drive_m(1'b1, 1'b0, 8'h10, 8'h00, cx);
    @(posedge clk_i);
    #1;
    rst = 1'b1;
    bus_m.req_valid = 1'b0;
    @(negedge clk_i);
    check("rst_mid_valid", {31'b0, bus_m.rsp_valid}, 32'd0);
    check("rst_mid_data", {24'b0, bus_m.rsp_data}, 32'd0);
    repeat (2) @(posedge clk_i);
    #1 rst = 1'b0;
    wait_ready(n);
    check("reinit_cycles", n, 256);
    check("rst_discard", log_m.size(), 0);
    drive_m(1'b1, 1'b0, 8'h10, 8'h00, c0);
    drive_m(1'b0, 1'b0, 8'h00, 8'h00, cx);
    drain();
    expect_ev("reswept", log_m, 0, c0 + L, 1'b1, 1'b0, 8'h00);
    log_m.delete();

    // 6: four back-to-back reads give four consecutive pulses.
    drive_m(1'b1, 1'b0, 8'h00, 8'h00, c0);
    drive_m(1'b1, 1'b0, 8'h01, 8'h00, cx);
    drive_m(1'b1, 1'b0, 8'h02, 8'h00, cx);
    drive_m(1'b1, 1'b0, 8'h10, 8'h00, cx);
    drive_m(1'b0, 1'b0, 8'h00, 8'h00, cx);
    drain();
    check("b2b_count", log_m.size(), 4);
    expect_ev("b2b0", log_m, 0, c0 + L, 1'b1, 1'b0, 8'h04);
    expect_ev("b2b1", log_m, 1, c0 + L + 1, 1'b1, 1'b0, 8'h3C);
    expect_ev("b2b2", log_m, 2, c0 + L + 2, 1'b1, 1'b0, 8'h00);
    expect_ev("b2b3", log_m, 3, c0 + L + 3, 1'b1, 1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
